fwd_source_pipe: RTL and testbench
==================================

# fwd_source_pipe

Producer-side companion of the E-stage forwarding selector. It carries each issued instruction's word and write-destination class from D through E, M and W. It drives `IR_E/IR_M/IR_W`, `user_bus_E`, and ready-qualified `forward_bus_M/W` for the selector. It also raises `stall_D` on load-use and busy mult/div hazards, inserting a bubble into E.

## Interface
Parameters:
- `MD_LAT`, default 32: mult/div busy cycles after issue; legal range 1..63.

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `IR_D` in 32: instruction in D.
- `user_bus_D` in 2: bit 1 = D reads rs, bit 0 = D reads rt.
- `forward_bus_D` in 3: D write destination; bit 2 rd, bit 1 rt, bit 0 $31; at most one bit set.
- `load_D` in 1: D result is produced in M (load class); 0 means ALU class.
- `md_start_D` in 1: D starts mult/div.
- `md_use_D` in 1: D reads HI/LO.
- `flush_E` in 1: squash the instruction entering E.
- `IR_E`, `IR_M`, `IR_W` out 32 each: stage instruction registers.
- `user_bus_E` out 2: registered `user_bus_D`.
- `forward_bus_M` out 3: M destination class, zeroed while M holds a load.
- `forward_bus_W` out 3: W destination class.
- `stall_D` out 1: hold F/D; bubble into E.
- `md_busy` out 1: mult/div unit busy.

## Operation
- Destination decode per stage: `dst` = IR[15:11] if class bit 2; IR[20:16] if bit 1; 31 if bit 0; else 0. Destination 0 never causes a hazard.
- Load-use hazard `lu` is true when E holds a load, `dst_E` is not 0, and either:
  - `user_bus_D[1]` is set and IR_D[25:21] equals `dst_E`, or
  - `user_bus_D[0]` is set and IR_D[20:16] equals `dst_E`.
- `stall_D` = `lu` OR (`md_busy` AND (`md_use_D` OR `md_start_D`)). It is combinational from D inputs and registered state.
- Each edge, E loads from D, M from E, and W from M. The fields moved are IR, user bus, class bits and load flag.
- E receives a bubble instead when `stall_D` or `flush_E` is set. A bubble is IR 0, user bus 0, class 0, load 0. M and W always advance, so there is no back-pressure below E.
- `forward_bus_M` equals class_M AND NOT load_M. `forward_bus_W` equals class_W.
- Mult/div counter:
  - Loads `MD_LAT` when `md_start_D` is set and neither `stall_D` nor `flush_E` is set.
  - Otherwise decrements while nonzero.
  - `md_busy` = counter not 0.
  - A flush never aborts a running count; a squashed start never loads.
- Simultaneous stall and flush: a single bubble.

## Timing
- Reset values: all IR 0, all buses 0, counter 0, `md_busy` 0, `stall_D` 0 (given idle D inputs).
- Reset deasserted mid-operation restarts from the empty pipeline; the counter is cleared.
- Latency D→E→M→W is one cycle per stage.
- A load-use stall lasts exactly one cycle. After it, the consumer reaches E as the load reaches W, so it is forwarded from W.
- Mult/div issued at edge t: `md_busy` is high for cycles t+1 … t+`MD_LAT`. A consumer in D stalls through those cycles and enters E at edge t+`MD_LAT`+1.

## Configuration
- `FWD_MD_STALL_EN` defined: counter, `md_busy`, and mult/div terms of `stall_D` are present.
- Not defined: counter removed, `md_busy` tied 0, `md_start_D`/`md_use_D` ignored, `stall_D` = `lu` only.

## Structure
- Package `fwd_pkg`:
  - IR field ranges for rs/rt/rd.
  - Class bit positions FWD_RD=2, FWD_RT=1, FWD_31=0.
  - Register 31 constant.
  - Bubble value.
- One sub-module `fwd_md_tracker`: contains the counter and busy logic, instantiated only under `FWD_MD_STALL_EN`.

## Test plan
- ALU chain, rd=3 (`forward_bus_D` 100), then a consumer with rs=3:
  - `stall_D`=0.
  - Next cycle `forward_bus_M`=100 and IR_M[15:11]=3.
- Load rt=5 (`load_D`=1, class 010), then a consumer with rt=5:
  - `stall_D`=1 for one cycle and IR_E=0.
  - At the following cycle `forward_bus_M`=000.
  - When the consumer is in E, `forward_bus_W`=010.
- Load with rt=0, then a consumer reading $0: `stall_D`=0 and no bubble.
- jal (class 001), then a consumer with rs=31: `forward_bus_M`=001 with no stall. `flush_E` on the jal gives IR_E=0 and `forward_bus_M`=000 next cycle.
- `MD_LAT`=4: issue mult, then mfhi in D.
  - `md_busy` high for 4 cycles and `stall_D` high for 4 cycles.
  - mfhi reaches E on the 5th edge.
  - `resetn` low mid-count clears `md_busy` immediately.
- Stall and flush in the same cycle: exactly one bubble in E, and M/W advance normally.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the forwarding source pipeline.
//   - MIPS-style register field ranges (rs/rt/rd)
//   - destination class bit positions (FWD_RD/FWD_RT/FWD_31)
//   - register 31 constant
//   - stage payload struct and its bubble value
//   - dst_of(): destination register decode from IR + class bits
package fwd_pkg;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam int FWD_RD = 2;
  localparam int FWD_RT = 1;
  localparam int FWD_31 = 0;

  localparam logic [4:0] REG_31 = 5'd31;

  // Payload carried from D into E.
  typedef struct packed {
    logic [31:0] ir;
    logic [1:0]  ub;
    logic [2:0]  cls;
    logic        ld;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // Class is one-hot or zero; priority order only matters for illegal input.
  function automatic logic [4:0] dst_of(input logic [31:0] ir, input logic [2:0] cls);
    logic [4:0] d;
    d = 5'd0;
    if (cls[FWD_RD])      d = ir[RD_HI:RD_LO];
    else if (cls[FWD_RT]) d = ir[RT_HI:RT_LO];
    else if (cls[FWD_31]) d = REG_31;
    return d;
  endfunction

endpackage

// File: rtl/fwd_md_tracker.sv
// fwd_md_tracker: mult/div busy counter.
//   clk, resetn : clock, async active-low reset
//   start       : accepted mult/div issue this cycle (already qualified by stall/flush)
//   busy        : counter non-zero
// Only instantiated when FWD_MD_STALL_EN is defined.
module fwd_md_tracker #(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic busy
);

  localparam logic [5:0] LAT = 6'(MD_LAT);

  logic [5:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 6'd0;
    end else if (start) begin
      count <= LAT;
    end else if (count != 6'd0) begin
      count <= count - 6'd1;
    end
  end

  assign busy = (count != 6'd0);

endmodule

// File: rtl/fwd_source_pipe.sv
// fwd_source_pipe: carries instruction word and destination class D->E->M->W
// and produces the producer-side buses for the E-stage forwarding selector.
//   clk, resetn          : clock, async active-low reset
//   IR_D, user_bus_D     : D instruction and its rs/rt read flags
//   forward_bus_D, load_D: D destination class (rd/rt/$31) and load flag
//   md_start_D, md_use_D : D starts mult/div / reads HI-LO
//   flush_E              : squash the instruction entering E
//   IR_E/IR_M/IR_W       : stage instruction registers
//   user_bus_E           : registered read flags of E
//   forward_bus_M/W      : ready-qualified destination classes of M/W
//   stall_D              : hold F/D, bubble into E
//   md_busy              : mult/div unit busy
// Optional feature macro: FWD_MD_STALL_EN (mult/div busy tracking and stall).
//
// Handshake: no valid/ready pair here; stall_D is the only back-pressure and
// it only holds D. E, M and W advance every cycle.
module fwd_source_pipe
  import fwd_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] IR_D,
  input  logic [1:0]  user_bus_D,
  input  logic [2:0]  forward_bus_D,
  input  logic        load_D,
  input  logic        md_start_D,
  input  logic        md_use_D,
  input  logic        flush_E,
  output logic [31:0] IR_E,
  output logic [31:0] IR_M,
  output logic [31:0] IR_W,
  output logic [1:0]  user_bus_E,
  output logic [2:0]  forward_bus_M,
  output logic [2:0]  forward_bus_W,
  output logic        stall_D,
  output logic        md_busy
);

  stage_t      e_q;
  logic [31:0] ir_m, ir_w;
  logic [2:0]  cls_m, cls_w;
  logic        ld_m;

  logic [4:0]  dst_e;
  logic        lu;
  logic        md_stall;

  assign dst_e = dst_of(e_q.ir, e_q.cls);

  // A load in E has no data until M completes; a dependent in D must wait.
  assign lu = e_q.ld && (dst_e != 5'd0) &&
              ((user_bus_D[1] && (IR_D[RS_HI:RS_LO] == dst_e)) ||
               (user_bus_D[0] && (IR_D[RT_HI:RT_LO] == dst_e)));

`ifdef FWD_MD_STALL_EN
  logic md_accept;

  // A stalled or squashed start never reaches E, so it must not load the counter.
  assign md_accept = md_start_D && !stall_D && !flush_E;

  fwd_md_tracker #(.MD_LAT(MD_LAT)) u_md (
    .clk    (clk),
    .resetn (resetn),
    .start  (md_accept),
    .busy   (md_busy)
  );

  assign md_stall = md_busy && (md_use_D || md_start_D);
`else
  logic unused_md;
  assign unused_md = md_start_D | md_use_D;
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  assign stall_D = lu || md_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q   <= BUBBLE;
      ir_m  <= 32'd0;
      cls_m <= 3'd0;
      ld_m  <= 1'b0;
      ir_w  <= 32'd0;
      cls_w <= 3'd0;
    end else begin
      // Stall and flush together still give a single bubble.
      if (stall_D || flush_E) begin
        e_q <= BUBBLE;
      end else begin
        e_q <= '{ir: IR_D, ub: user_bus_D, cls: forward_bus_D, ld: load_D};
      end
      ir_m  <= e_q.ir;
      cls_m <= e_q.cls;
      ld_m  <= e_q.ld;
      ir_w  <= ir_m;
      cls_w <= cls_m;
    end
  end

  assign IR_E          = e_q.ir;
  assign user_bus_E    = e_q.ub;
  assign IR_M          = ir_m;
  assign IR_W          = ir_w;
  // A load's value is not ready in M, so it is not advertised there.
  assign forward_bus_M = ld_m ? 3'b000 : cls_m;
  assign forward_bus_W = cls_w;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// tb_fwd_source_pipe: directed and randomized checks of fwd_source_pipe
// against a stage-list reference model with a cycle-number mult/div window.
module tb_fwd_source_pipe;

  localparam int MD_LAT = 4;
`ifdef FWD_MD_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] IR_D = '0;
  logic [1:0]  user_bus_D = '0;
  logic [2:0]  forward_bus_D = '0;
  logic        load_D = 1'b0, md_start_D = 1'b0, md_use_D = 1'b0, flush_E = 1'b0;
  logic [31:0] IR_E, IR_M, IR_W;
  logic [1:0]  user_bus_E;
  logic [2:0]  forward_bus_M, forward_bus_W;
  logic        stall_D, md_busy;

  fwd_source_pipe #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .resetn(resetn), .IR_D(IR_D), .user_bus_D(user_bus_D),
    .forward_bus_D(forward_bus_D), .load_D(load_D), .md_start_D(md_start_D),
    .md_use_D(md_use_D), .flush_E(flush_E), .IR_E(IR_E), .IR_M(IR_M),
    .IR_W(IR_W), .user_bus_E(user_bus_E), .forward_bus_M(forward_bus_M),
    .forward_bus_W(forward_bus_W), .stall_D(stall_D), .md_busy(md_busy)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] ir;
    logic [1:0]  ub;
    logic [2:0]  cls;
    logic        ld;
  } instr_t;

  instr_t pipe[3];          // 0 = E, 1 = M, 2 = W
  int     cyc = 0;          // rising edges since start
  int     md_free_at = 0;   // first cycle count at which mult/div is idle
  int     n_vec = 0;
  int     n_err = 0;
  logic   last_stall_obs;
  logic   last_busy_obs;

  function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic int dest(input instr_t x);
    if (x.cls == 3'b100) return int'(x.ir[15:11]);
    if (x.cls == 3'b010) return int'(x.ir[20:16]);
    if (x.cls == 3'b001) return 31;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{ir: 32'd0, ub: 2'd0, cls: 3'd0, ld: 1'b0};
    md_free_at = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called one time unit after a rising edge; drives D, checks, clocks once.
  task automatic step(input logic [31:0] ir, input logic [1:0] ub, input logic [2:0] cls,
                      input logic ld, input logic st, input logic us, input logic fl);
    instr_t d;
    int     de;
    logic   lu, busy, stall;
    IR_D = ir; user_bus_D = ub; forward_bus_D = cls; load_D = ld;
    md_start_D = st; md_use_D = us; flush_E = fl;
    d  = '{ir: ir, ub: ub, cls: cls, ld: ld};
    de = dest(pipe[0]);
    lu = pipe[0].ld && de != 0 &&
         ((ub[1] && int'(ir[25:21]) == de) || (ub[0] && int'(ir[20:16]) == de));
    busy  = MD_EN && (cyc < md_free_at);
    stall = lu || (busy && (us || st));
    #3;
    last_stall_obs = stall_D;
    last_busy_obs  = md_busy;
    check("stall_D", 32'(stall_D), 32'(stall));
    check("md_busy", 32'(md_busy), 32'(busy));
    check("IR_E", IR_E, pipe[0].ir);
    check("user_bus_E", 32'(user_bus_E), 32'(pipe[0].ub));
    check("IR_M", IR_M, pipe[1].ir);
    check("IR_W", IR_W, pipe[2].ir);
    check("forward_bus_M", 32'(forward_bus_M), pipe[1].ld ? 32'd0 : 32'(pipe[1].cls));
    check("forward_bus_W", 32'(forward_bus_W), 32'(pipe[2].cls));
    @(posedge clk);
    if (MD_EN && st && !stall && !fl) md_free_at = cyc + 1 + MD_LAT;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (stall || fl) ? '{ir: 32'd0, ub: 2'd0, cls: 3'd0, ld: 1'b0} : d;
    cyc++;
    #1;
  endtask

  task automatic nop();
    step(32'd0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] cons, mfhi, jal;
    logic [31:0] r_ir;
    logic [1:0]  r_ub;
    logic [2:0]  r_cls;
    logic        r_ld, r_st, r_us;
    int          n_st, n_busy;

    model_reset();
    #2;
    check("reset_IR_E", IR_E, 32'd0);
    check("reset_fwd_M", 32'(forward_bus_M), 32'd0);
    check("reset_md_busy", 32'(md_busy), 32'd0);
    check("reset_stall", 32'(stall_D), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // ALU chain: rd=3 producer, rs=3 consumer
    step(mk(1, 2, 3), 2'b11, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    cons = mk(3, 4, 6);
    step(cons, 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("alu_stall", 32'(last_stall_obs), 32'd0);
    check("alu_fwd_M", 32'(forward_bus_M), 32'h4);
    check("alu_IR_M_rd", 32'(IR_M[15:11]), 32'd3);

    // Load rt=5, consumer reads rt=5: one stall cycle
    step(mk(2, 5, 0), 2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    cons = mk(7, 5, 8);
    step(cons, 2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_stall", 32'(last_stall_obs), 32'd1);
    check("lu_bubble", IR_E, 32'd0);
    check("lu_fwd_M_load", 32'(forward_bus_M), 32'd0);
    step(cons, 2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_second_no_stall", 32'(last_stall_obs), 32'd0);
    check("lu_cons_in_E", IR_E, cons);
    check("lu_fwd_W", 32'(forward_bus_W), 32'h2);

    // Load to $0 never stalls
    step(mk(2, 0, 0), 2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    cons = mk(0, 0, 9);
    step(cons, 2'b11, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("r0_no_stall", 32'(last_stall_obs), 32'd0);
    check("r0_in_E", IR_E, cons);

    // jal then rs=31 consumer; then flushed jal
    jal = 32'h0C00_0040;
    step(jal, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(31, 0, 10), 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("jal_no_stall", 32'(last_stall_obs), 32'd0);
    check("jal_fwd_M", 32'(forward_bus_M), 32'h1);
    step(jal, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_IR_E", IR_E, 32'd0);
    nop();
    check("flush_fwd_M", 32'(forward_bus_M), 32'd0);

    // Mult then mfhi
    step(mk(8, 9, 0), 2'b11, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    mfhi = mk(0, 0, 12) | 32'h10;
    n_st = 0; n_busy = 0;
    for (int k = 0; k < 10; k++) begin
      step(mfhi, 2'b00, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
      if (last_busy_obs) n_busy++;
      if (!last_stall_obs) break;
      n_st++;
    end
    check("md_stall_cycles", 32'(n_st), MD_EN ? 32'd4 : 32'd0);
    check("md_busy_cycles", 32'(n_busy), MD_EN ? 32'd4 : 32'd0);
    check("mfhi_in_E", IR_E, mfhi);

    // Reset in the middle of a mult/div count
    step(mk(8, 9, 0), 2'b11, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    nop();
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_md_busy", 32'(md_busy), 32'd0);
    check("rst_mid_IR_M", IR_M, 32'd0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Stall and flush in the same cycle: one bubble
    step(mk(2, 5, 0), 2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    cons = mk(5, 1, 13);
    step(cons, 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sf_stall", 32'(last_stall_obs), 32'd1);
    check("sf_bubble", IR_E, 32'd0);
    check("sf_M_advanced", IR_M, mk(2, 5, 0));
    step(cons, 2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sf_cons_in_E", IR_E, cons);

    // Randomized traffic; a stalled D instruction is re-presented
    r_ir = 32'd0; r_ub = 2'd0; r_cls = 3'd0; r_ld = 1'b0; r_st = 1'b0; r_us = 1'b0;
    last_stall_obs = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall_obs) begin
        r_ir  = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7))
                | 32'($urandom_range(0, 63));
        r_ub  = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: r_cls = 3'b000;
          1: r_cls = 3'b001;
          2: r_cls = 3'b010;
          default: r_cls = 3'b100;
        endcase
        r_ld = (r_cls == 3'b010) && ($urandom_range(0, 1) == 1);
        r_st = ($urandom_range(0, 15) == 0);
        r_us = ($urandom_range(0, 7) == 0);
      end
      step(r_ir, r_ub, r_cls, r_ld, r_st, r_us, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
